// File: rtl/switch_out_arbiter.sv
// -----------------------------------------------------------------------------
// switch_out_arbiter
//
// Output-side scheduler for a 4-port packet switch. Each input requester offers
// a single-word packet (data + address). The low address bits pick the
// destination output. A round-robin arbiter per output picks one requester.
// A one-entry holding register per output presents the packet until the
// downstream receiver consumes it.
//
// Handshakes:
//   input side : a packet moves at a rising edge where req_valid[i] and
//                req_ready[i] are both 1. req_valid never depends on
//                req_ready. The requester holds data/addr stable until that
//                edge. req_ready is combinational.
//   output side: data_rdy[j] means the holding register is full. The packet is
//                consumed at an edge where data_rdy[j] and data_read[j] are
//                both 1. data_read[j] is ignored while data_rdy[j] is 0.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NPORTS]      input i holds a packet
//   req_data   in   [NPORTS*DW]   input i data at [i*DW +: DW]
//   req_addr   in   [NPORTS*AW]   input i address; [1:0] = destination
//   req_ready  out  [NPORTS]      grant to input i (combinational)
//   data_out   out  [NPORTS*DW]   output j held data
//   addr_out   out  [NPORTS*AW]   output j held address
//   data_rdy   out  [NPORTS]      output j holding register full
//   data_read  in   [NPORTS]      receiver j consumes the held packet
// -----------------------------------------------------------------------------
module switch_out_arbiter #(
    parameter int NPORTS = 4,
    parameter int DW     = 16,
    parameter int AW     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NPORTS-1:0]    req_valid,
    input  logic [NPORTS*DW-1:0] req_data,
    input  logic [NPORTS*AW-1:0] req_addr,
    output logic [NPORTS-1:0]    req_ready,
    output logic [NPORTS*DW-1:0] data_out,
    output logic [NPORTS*AW-1:0] addr_out,
    output logic [NPORTS-1:0]    data_rdy,
    input  logic [NPORTS-1:0]    data_read
);

    localparam int PW = $clog2(NPORTS);

    // Unpacked views of the flat input buses
    logic [DW-1:0]     w_in_data [NPORTS];
    logic [AW-1:0]     w_in_addr [NPORTS];
    logic [PW-1:0]     w_dest    [NPORTS];

    // Per-output arbitration results
    logic [NPORTS-1:0] w_req     [NPORTS];
    logic [PW-1:0]     w_src     [NPORTS];
    logic [NPORTS-1:0] w_found;
    logic [NPORTS-1:0] w_load;

    // Holding registers and round-robin pointers
    logic [NPORTS-1:0] r_rdy;
    logic [PW-1:0]     r_ptr     [NPORTS];
    logic [DW-1:0]     r_data    [NPORTS];
    logic [AW-1:0]     r_addr    [NPORTS];

    for (genvar i = 0; i < NPORTS; i++) begin : g_unpack
        assign w_in_data[i] = req_data[i*DW +: DW];
        assign w_in_addr[i] = req_addr[i*AW +: AW];
        assign w_dest[i]    = req_addr[i*AW +: PW];
        assign data_out[i*DW +: DW] = r_data[i];
        assign addr_out[i*AW +: AW] = r_addr[i];
    end

    assign data_rdy = r_rdy;

    // Round-robin pick: the set bit closest to ptr going upward (with wrap).
    // Scanning offsets from the far end down lets the nearest one win last.
    // Wrap relies on NPORTS being a power of two (PW-bit addition).
    function automatic logic [PW:0] rr_pick(input logic [NPORTS-1:0] req,
                                            input logic [PW-1:0]     ptr);
        logic [PW:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            idx = ptr + PW'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        req_ready = '0;
        w_load    = '0;
        w_found   = '0;
        for (int j = 0; j < NPORTS; j++) begin
            w_req[j] = '0;
            w_src[j] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                w_req[j][i] = req_valid[i] & (w_dest[i] == PW'(j));
            end
            {w_found[j], w_src[j]} = rr_pick(w_req[j], r_ptr[j]);
            // Free when empty or draining this edge. rst_n masks grants so
            // req_ready drops as soon as reset asserts.
            w_load[j] = rst_n & w_found[j] & (~r_rdy[j] | data_read[j]);
            if (w_load[j]) begin
                req_ready[w_src[j]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy <= '0;
            for (int j = 0; j < NPORTS; j++) begin
                r_ptr[j]  <= '0;
                r_data[j] <= '0;
                r_addr[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NPORTS; j++) begin
                if (w_load[j]) begin
                    // Load wins over drain: back-to-back keeps data_rdy high.
                    r_data[j] <= w_in_data[w_src[j]];
                    r_addr[j] <= w_in_addr[w_src[j]];
                    r_rdy[j]  <= 1'b1;
                    r_ptr[j]  <= w_src[j] + PW'(1);
                end else if (data_read[j]) begin
                    // Data/address deliberately kept; only the full flag clears.
                    r_rdy[j] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_out_arbiter.sv
module tb_switch_out_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [63:0] req_addr;
  logic [3:0]  req_ready;
  logic [63:0] data_out;
  logic [63:0] addr_out;
  logic [3:0]  data_rdy;
  logic [3:0]  data_read;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] exp_q[$];

  switch_out_arbiter #(.NPORTS(4), .DW(16), .AW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .data_out  (data_out),
    .addr_out  (addr_out),
    .data_rdy  (data_rdy),
    .data_read (data_read)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_port(input int i, input logic [15:0] d, input logic [15:0] a);
    req_data[i*16 +: 16] = d;
    req_addr[i*16 +: 16] = a;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    data_read = '0;
    req_data  = '0;
    req_addr  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Expects the winners in exp_q order; each winner drops valid once served.
  task automatic run_grants(input int n);
    logic [1:0] w;
    for (int s = 0; s < n; s++) begin
      w = exp_q.pop_front();
      #1 check("contend_ready", {60'd0, req_ready}, {60'd0, 4'b0001 << w});
      @(posedge clk); #1;
      check("contend_data", {48'd0, data_out[63:48]}, {48'd0, 16'hD000 + 16'(w)});
      @(negedge clk);
      req_valid[w] = 1'b0;
    end
  endtask

  // vector table: state is empty with all pointers 0 before each vector
  typedef struct {
    logic [3:0] valid;
    logic [7:0] dests;      // input i destination at [2i +: 2]
    logic [3:0] exp_ready;
    logic [3:0] exp_rdy;
  } vec_t;

  vec_t vecs[8];

  // reference model state for random phase
  int          m_ptr[4];
  logic        m_rdy[4];
  logic [15:0] m_data[4];
  logic [15:0] m_addr[4];
  logic        pv[4];
  logic [15:0] pd[4];
  logic [15:0] pa[4];
  int          wait_cnt[4];
  int          worst_wait;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    data_read = '0;
    req_data  = '0;
    req_addr  = '0;

    // ---------------- reset with all requesters active ----------------
    for (int i = 0; i < 4; i++) set_port(i, 16'hC000 + 16'(i), 16'h4440 + 16'(i));
    req_valid = 4'hF;
    @(negedge clk); #1;
    check("rst_ready",    {60'd0, req_ready}, 64'd0);
    check("rst_data_rdy", {60'd0, data_rdy},  64'd0);
    check("rst_data_out", data_out, 64'd0);
    check("rst_addr_out", addr_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_ready", {60'd0, req_ready}, 64'hF);
    @(posedge clk); #1;
    check("rel_data_rdy", {60'd0, data_rdy}, 64'hF);
    check("rel_data_out", data_out, 64'hC003_C002_C001_C000);
    check("rel_addr_out", addr_out, 64'h4443_4442_4441_4440);

    // ---------------- table-driven single-edge vectors ----------------
    vecs[0] = '{4'b0100, 8'h10, 4'b0100, 4'b0010};
    vecs[1] = '{4'b1111, 8'hFF, 4'b0001, 4'b1000};
    vecs[2] = '{4'b1111, 8'hE4, 4'b1111, 4'b1111};
    vecs[3] = '{4'b1111, 8'h0A, 4'b0101, 4'b0101};
    vecs[4] = '{4'b1010, 8'h55, 4'b0010, 4'b0010};
    vecs[5] = '{4'b0000, 8'hE4, 4'b0000, 4'b0000};
    vecs[6] = '{4'b1100, 8'h00, 4'b0100, 4'b0001};
    vecs[7] = '{4'b1011, 8'h47, 4'b0011, 4'b1010};
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int i = 0; i < 4; i++)
        set_port(i, 16'(v * 256 + i), 16'hB000 | 16'(i << 4) | 16'(vecs[v].dests[2*i +: 2]));
      req_valid = vecs[v].valid;
      #1 check("vec_ready", {60'd0, req_ready}, {60'd0, vecs[v].exp_ready});
      @(posedge clk); #1;
      check("vec_data_rdy", {60'd0, data_rdy}, {60'd0, vecs[v].exp_rdy});
    end

    // ---------------- single packet ----------------
    do_reset();
    set_port(2, 16'hA5A5, 16'h1231);
    req_valid = 4'b0100;
    #1 check("single_ready", {60'd0, req_ready}, 64'h4);
    @(posedge clk); #1;
    check("single_data", {48'd0, data_out[31:16]}, 64'hA5A5);
    check("single_addr", {48'd0, addr_out[31:16]}, 64'h1231);
    check("single_rdy",  {60'd0, data_rdy}, 64'h2);
    @(negedge clk);
    req_valid = '0;
    data_read = 4'b0010;
    @(posedge clk); #1;
    check("drain_rdy",  {60'd0, data_rdy}, 64'h0);
    check("drain_hold", {48'd0, data_out[31:16]}, 64'hA5A5);
    @(negedge clk);
    data_read = '0;

    // ---------------- contention at output 3 ----------------
    do_reset();
    for (int i = 0; i < 4; i++) set_port(i, 16'hD000 + 16'(i), 16'h0F03 | 16'(i << 8));
    data_read = 4'b1000;
    req_valid = 4'hF;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    run_grants(4);
    req_valid = 4'b1010;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    run_grants(2);
    data_read = '0;

    // ---------------- back-to-back stream to output 2 ----------------
    do_reset();
    data_read = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      set_port(0, 16'(k), 16'h0002);
      req_valid = 4'b0001;
      #1 check("b2b_ready", {63'd0, req_ready[0]}, 64'd1);
      @(posedge clk); #1;
      check("b2b_rdy",  {63'd0, data_rdy[2]}, 64'd1);
      check("b2b_data", {48'd0, data_out[47:32]}, 64'(k));
      @(negedge clk);
    end
    req_valid = '0;
    data_read = '0;

    // ---------------- backpressure at output 0 ----------------
    do_reset();
    set_port(0, 16'h1111, 16'h0000);
    req_valid = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b0010;
    set_port(1, 16'h2222, 16'h0010);
    for (int c = 0; c < 5; c++) begin
      #1 check("bp_ready", {63'd0, req_ready[1]}, 64'd0);
      @(posedge clk); #1;
      check("bp_hold", {48'd0, data_out[15:0]}, 64'h1111);
      check("bp_rdy",  {63'd0, data_rdy[0]}, 64'd1);
      @(negedge clk);
    end
    data_read = 4'b0001;
    #1 check("bp_release_ready", {63'd0, req_ready[1]}, 64'd1);
    @(posedge clk); #1;
    check("bp_refill", {48'd0, data_out[15:0]}, 64'h2222);
    check("bp_refill_rdy", {63'd0, data_rdy[0]}, 64'd1);
    @(negedge clk);
    req_valid = '0;
    data_read = '0;

    // ---------------- reset mid-operation ----------------
    do_reset();
    for (int i = 0; i < 4; i++) set_port(i, 16'hE000 + 16'(i), 16'h7770 + 16'(i));
    req_valid = 4'hF;
    @(posedge clk); #1;
    check("mid_full", {60'd0, data_rdy}, 64'hF);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_rdy",   {60'd0, data_rdy}, 64'd0);
    check("mid_rst_data",  data_out, 64'd0);
    check("mid_rst_addr",  addr_out, 64'd0);
    check("mid_rst_ready", {60'd0, req_ready}, 64'd0);

    // ---------------- randomized run against reference model ----------------
    do_reset();
    for (int j = 0; j < 4; j++) begin
      m_ptr[j] = 0; m_rdy[j] = 1'b0; m_data[j] = '0; m_addr[j] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0; pd[i] = '0; pa[i] = '0; wait_cnt[i] = 0;
    end
    worst_wait = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      logic [3:0]  exp_ready;
      logic [63:0] exp_do, exp_ao;
      logic [3:0]  exp_rdy;
      int          winner[4];
      // new packets only where the requester is idle; pending ones stay put
      for (int i = 0; i < 4; i++) begin
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i] = 1'b1;
          pd[i] = 16'($urandom);
          pa[i] = 16'($urandom);
        end
        req_valid[i] = pv[i];
        set_port(i, pd[i], pa[i]);
      end
      for (int j = 0; j < 4; j++) data_read[j] = ($urandom_range(0, 3) != 0);

      // model: winner is the pending requester nearest above the pointer
      exp_ready = '0;
      for (int j = 0; j < 4; j++) begin
        int best_d;
        winner[j] = -1;
        best_d = 99;
        for (int i = 0; i < 4; i++) begin
          if (pv[i] && int'(pa[i][1:0]) == j && ((i - m_ptr[j] + 4) % 4) < best_d) begin
            best_d = (i - m_ptr[j] + 4) % 4;
            winner[j] = i;
          end
        end
        if (winner[j] >= 0 && !(m_rdy[j] && !data_read[j])) exp_ready[winner[j]] = 1'b1;
        else winner[j] = -1;
      end

      #1 check("rand_ready", {60'd0, req_ready}, {60'd0, exp_ready});

      // fairness, measured on what the design actually granted
      for (int i = 0; i < 4; i++) begin
        if (pv[i]) begin
          if (req_ready[i]) wait_cnt[i] = 0;
          else begin
            for (int k = 0; k < 4; k++)
              if (k != i && req_ready[k] && pa[k][1:0] == pa[i][1:0]) wait_cnt[i]++;
            if (wait_cnt[i] > worst_wait) worst_wait = wait_cnt[i];
          end
        end
      end

      for (int j = 0; j < 4; j++) begin
        if (winner[j] >= 0) begin
          m_data[j] = pd[winner[j]];
          m_addr[j] = pa[winner[j]];
          m_rdy[j]  = 1'b1;
          m_ptr[j]  = (winner[j] + 1) % 4;
          pv[winner[j]] = 1'b0;
          wait_cnt[winner[j]] = 0;
        end else if (m_rdy[j] && data_read[j]) begin
          m_rdy[j] = 1'b0;
        end
        exp_do[j*16 +: 16] = m_data[j];
        exp_ao[j*16 +: 16] = m_addr[j];
        exp_rdy[j]         = m_rdy[j];
      end

      @(posedge clk); #1;
      check("rand_data_rdy", {60'd0, data_rdy}, {60'd0, exp_rdy});
      check("rand_data_out", data_out, exp_do);
      check("rand_addr_out", addr_out, exp_ao);
      @(negedge clk);
    end
    check("rr_wait_over3", {63'd0, (worst_wait > 3)}, 64'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_out_arbiter.md
# switch_out_arbiter

Output-side scheduler for the 4-port packet switch. It accepts single-word packets (16-bit data + 16-bit address) from four input requesters and routes each to the output port selected by its address. A round-robin arbiter per output port resolves contention, and a one-entry holding register per output drives `data_out`/`addr_out`/`data_rdy` until the downstream receiver pulses `data_read`.

## Interface
- `NPORTS`, 4: number of input and output ports. Design is verified at 4 only.
- `DW`, 16: data word width per port.
- `AW`, 16: address width per port. Bits `[1:0]` select the destination output port.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NPORTS  input port i holds a packet.
- `req_data`  in  NPORTS*DW  packet data; port i at `[i*DW +: DW]`.
- `req_addr`  in  NPORTS*AW  packet address; port i at `[i*AW +: AW]`.
- `req_ready`  out  NPORTS  combinational grant; the packet transfers at the edge where `req_valid[i] & req_ready[i]`.
- `data_out`  out  NPORTS*DW  output port j data at `[j*DW +: DW]`.
- `addr_out`  out  NPORTS*AW  output port j address, passed through unmodified.
- `data_rdy`  out  NPORTS  output port j holding register full.
- `data_read`  in  NPORTS  receiver j consumes the held packet; ignored when `data_rdy[j]` = 0.

## Operation
- Destination of input i: `dest_i = req_addr[i*AW +: 2]`. Every 2-bit value is a valid destination.
- Per output j:
  - Request vector `r_j[i] = req_valid[i] & (dest_i == j)`.
  - Output j is free when `!data_rdy[j] | data_read[j]`.
- Arbitration per output j:
  - Round-robin over `r_j`, starting search at pointer `ptr_j` (2 bits) and scanning upward with wrap 3→0.
  - First set bit wins.
  - `req_ready[i]` = 1 only when i wins at its destination output and that output is free.
  - At most one `req_ready` bit is set per output.
  - An input asserts `req_ready` for at most one output, namely its own destination.
- On a transfer from i to j at an edge:
  - `data_out[j]` ← `req_data[i]`, `addr_out[j]` ← `req_addr[i]`, `data_rdy[j]` ← 1.
  - `ptr_j` ← `(i+1) mod 4`.
- On drain (`data_rdy[j] & data_read[j]`) with no refill at the same edge:
  - `data_rdy[j]` ← 0.
  - `data_out[j]` and `addr_out[j]` hold their last value and are not cleared.
- Invariant: `data_out`/`addr_out` slices change only on a load edge, so after any change `data_rdy[j]` = 1.
- `ptr_j` changes only on a grant.
- Requesters must keep `req_valid`/`req_data`/`req_addr` stable until accepted. `req_valid` has no ready dependency.

## Timing
- Reset (async assert, `rst_n` = 0): `data_rdy` = 0, `data_out` = 0, `addr_out` = 0, all `ptr_j` = 0, `req_ready` = 0 (outputs forced because `data_rdy` = 0 gates nothing; `req_ready` is explicitly masked while `rst_n` = 0).
- Reset release is synchronous to `clk` in the system. The first grant can occur on the first edge after deassertion.
- Latency: packet accepted at edge N → `data_rdy[j]` = 1 and data valid immediately after edge N (1 cycle).
- Back-to-back: drain and refill at the same edge keep `data_rdy[j]` = 1 and load new data. Sustained throughput is 1 packet/cycle/output.
- Full output with no `data_read[j]`: all `r_j` requesters see `req_ready` = 0 and stall indefinitely.
- `data_read[j]` while `data_rdy[j]` = 0: no effect.
- Contention: requesters to one output are served in rotating order. No requester waits more than 3 grants at that output.
- Different destinations are independent: up to 4 transfers per edge.
- Reset mid-operation: held packets are discarded. `req_ready` drops asynchronously.

## Test plan
- Reset: hold `rst_n` = 0 with `req_valid` = 4'hF → `req_ready` = 0, `data_rdy` = 0, `data_out` = 0. After release with `data_read` = 0, exactly one transfer per output occurs at the first edge.
- Single packet: input 2 sends data 16'hA5A5, addr 16'h1231 (dest 1) → `req_ready` = 4'b0100 at edge 1. After edge 1: `data_out[31:16]` = A5A5, `addr_out[31:16]` = 1231, `data_rdy` = 4'b0010. `data_read[1]` at edge 2 → `data_rdy` = 0 and data holds A5A5.
- Contention: inputs 0–3 all target dest 3, with `data_read[3]` held 1 → grant order 0,1,2,3 on successive edges. Then ptr_3 = 0. Re-request from inputs 1 and 3 only → order 1, then 3.
- Back-to-back: input 0 streams 8 packets (data 0..7) to dest 2 with `data_read[2]` = 1 → `data_rdy[2]` stays 1 for 8 cycles, `data_out[47:32]` steps 0..7, 1 packet/cycle.
- Backpressure: dest 0 full with `data_read[0]` = 0 for 5 cycles while input 1 requests → `req_ready[1]` = 0 and `data_out[15:0]` unchanged throughout. `data_read[0]` = 1 → input 1 loads at that edge.
- Mid-operation reset: all four outputs full, assert `rst_n` = 0 between edges → `data_rdy` = 0 and `data_out` = 0 immediately, before the next edge.
